word_cmd_interface: RTL

WORD_CMD_INTERFACE -- requirements
Module: word_cmd_interface

---
 rtl/word_cmd_pkg.sv | 57 +++++
 rtl/cycle_watchdog.sv | 51 +++++
 rtl/word_cmd_interface.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_cmd_pkg.sv
// ---------------------------------------------------------------------------
// word_cmd_pkg
//
// Purpose:
//   Shared definitions for the word command interface. It holds the
//   sequencer state enum, the bit positions of the header fields inside a
//   host word, and a helper that sizes the trigger-acknowledge watchdog
//   counter.
//
// Contents:
//   state_t          : sequencer states S_INIT .. S_RUN
//   HDR_* localparams: header field positions (cmd, len, quad)
//   CMD_W / LEN_W    : widths of the cmd and len header fields
//   timeoutCntWidth(): counter width needed to count 0 .. cycles-1
// ---------------------------------------------------------------------------
package word_cmd_pkg;

  // Sequencer states.
  //   S_INIT  : waiting for the controller to finish its own start-up
  //   S_IDLE  : ready for a header word
  //   S_LOAD  : collecting payload words into data_send
  //   S_DRAIN : swallowing the payload of an oversize request
  //   S_FIRE  : trigger raised, waiting for the controller to pick it up
  //   S_RUN   : controller is busy, waiting for it to finish
  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_FIRE  = 3'd4,
    S_RUN   = 3'd5
  } state_t;

  // Header word layout. Bits above HDR_QUAD_BIT are ignored.
  localparam int HDR_CMD_LSB  = 0;
  localparam int HDR_CMD_MSB  = 7;
  localparam int HDR_LEN_LSB  = 8;
  localparam int HDR_LEN_MSB  = 15;
  localparam int HDR_QUAD_BIT = 16;

  localparam int CMD_W = HDR_CMD_MSB - HDR_CMD_LSB + 1;
  localparam int LEN_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  // Smallest width (at least 1) able to hold the values 0 .. cycles-1.
  // The watchdog counts up to cycles-1 and flags expiry on that value.
  function automatic int timeoutCntWidth(input int cycles);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < cycles) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/cycle_watchdog.sv
// ---------------------------------------------------------------------------
// cycle_watchdog
//
// Purpose:
//   Counts consecutive clock cycles while 'start' is held and raises
//   'expired' combinationally on the LIMIT-th such cycle, so the owner can
//   act on the same edge that completes the allowed window. 'clear' (or
//   reset) returns the count to zero.
//
// Parameters:
//   LIMIT    : number of cycles allowed before expiry (>= 1)
//
// Ports:
//   clk_in   in  : clock
//   reset    in  : synchronous, active-high reset
//   start    in  : count enable, held for the whole watched window
//   clear    in  : synchronous clear of the count
//   expired  out : high during the LIMIT-th counted cycle
// ---------------------------------------------------------------------------
module cycle_watchdog
  import word_cmd_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic clk_in,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = timeoutCntWidth(LIMIT);

  logic [CNT_W-1:0] r_count;

  // The count sits at LIMIT-1 during the last allowed cycle; flagging
  // expiry there lets the owner leave its wait state on exactly the
  // LIMIT-th edge.
  assign expired = start && !clear && (r_count == CNT_W'(LIMIT - 1));

  // Count up while enabled; stop at the expiry value so a stuck 'start'
  // cannot wrap the counter back to a non-expired value.
  always_ff @(posedge clk_in) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (start && !expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/word_cmd_interface.sv
// ---------------------------------------------------------------------------
// word_cmd_interface
//
// Purpose:
//   Bridges a simple host word port to a memory/flash style command
//   controller. The host writes a header word (cmd, payload length in
//   words, quad flag) followed by that many payload words. Payload words
//   are shifted into data_send (newest word at the LSBs); when the last
//   word lands, trigger is raised and held until the controller reports
//   busy. When the controller goes idle again its readout is captured and
//   readout_valid pulses for one cycle.
//
//   Requests whose payload would exceed MAX_BYTES set len_err; their
//   payload words are still consumed (so the host stays in sync) but are
//   not stored and no trigger is issued.
//
// Configuration macro:
//   WORD_CMD_TIMEOUT_EN : when defined, a cycle_watchdog bounds the wait
//                         for the controller to acknowledge trigger to
//                         TIMEOUT_CYC cycles; on expiry trigger drops,
//                         timeout_err is set and the block returns to
//                         idle. When undefined the wait is unbounded and
//                         timeout_err is constant 0.
//
// Parameters:
//   HOST_W      : host word width, 32 or 64
//   MAX_BYTES   : payload buffer capacity in bytes
//   READ_W      : controller readout width
//   TIMEOUT_CYC : trigger acknowledge window (only with the macro)
//
// Ports (host side):
//   clk_in        in               : clock
//   reset         in               : synchronous, active-high reset
//   wr            in               : host word strobe
//   wdata         in  [HOST_W]     : header or payload word
//   busy          out              : header cannot be accepted now
//   error         out              : mc_error | len_err | timeout_err
//   len_err       out              : last header asked for too many bytes
//   timeout_err   out              : last trigger was never acknowledged
//   readout       out [READ_W]     : captured controller readout
//   readout_valid out              : one-cycle pulse on readout update
//
// Ports (controller side):
//   trigger       out              : start request to the controller
//   quad          out              : quad mode flag from the header
//   cmd           out [8]          : command byte from the header
//   data_send     out [MAX_BYTES*8]: payload shift buffer
//   mc_busy       in               : controller busy
//   mc_error      in               : controller error
//   mc_readout    in  [READ_W]     : controller readout data
// ---------------------------------------------------------------------------
module word_cmd_interface
  import word_cmd_pkg::*;
#(
  parameter int HOST_W      = 32,
  parameter int MAX_BYTES   = 259,
  parameter int READ_W      = 64,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [HOST_W-1:0]      wdata,
  output logic                   busy,
  output logic                   error,
  output logic                   len_err,
  output logic                   timeout_err,
  output logic [READ_W-1:0]      readout,
  output logic                   readout_valid,
  output logic                   trigger,
  output logic                   quad,
  output logic [CMD_W-1:0]       cmd,
  output logic [MAX_BYTES*8-1:0] data_send,
  input  logic                   mc_busy,
  input  logic                   mc_error,
  input  logic [READ_W-1:0]      mc_readout
);

  localparam int DATA_W         = MAX_BYTES * 8;
  localparam int BYTES_PER_WORD = HOST_W / 8;

  state_t r_state;
  state_t w_nextState;

  logic              r_busy;
  logic              r_trigger;
  logic              r_quad;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_dataSend;
  logic [READ_W-1:0] r_readout;
  logic              r_readoutValid;
  logic              r_lenErr;
  logic [LEN_W-1:0]  r_remain;

  logic [CMD_W-1:0]  w_hdrCmd;
  logic [LEN_W-1:0]  w_hdrLen;
  logic              w_hdrQuad;
  logic [31:0]       w_reqBytes;
  logic              w_lenTooBig;
  logic              w_hdrNoPayload;
  logic              w_lastWord;
  logic              w_timeout;

  // Header decode is applied to wdata unconditionally; it only matters in
  // S_IDLE when wr is high.
  assign w_hdrCmd       = wdata[HDR_CMD_MSB:HDR_CMD_LSB];
  assign w_hdrLen       = wdata[HDR_LEN_MSB:HDR_LEN_LSB];
  assign w_hdrQuad      = wdata[HDR_QUAD_BIT];
  assign w_reqBytes     = 32'(w_hdrLen) * 32'(BYTES_PER_WORD);
  assign w_lenTooBig    = w_reqBytes > 32'(MAX_BYTES);
  assign w_hdrNoPayload = (w_hdrLen == '0);

  // The remaining count is loaded with len from the header, so the word
  // accepted while it reads 1 is the final one of the transfer.
  assign w_lastWord = wr && (r_remain == LEN_W'(1));

`ifdef WORD_CMD_TIMEOUT_EN
  logic w_wdStart;
  logic w_wdClear;
  logic r_timeoutErr;

  // The watchdog only runs while trigger is waiting for acknowledgement;
  // any other state holds it cleared so each trigger gets a full window.
  assign w_wdStart = (r_state == S_FIRE);
  assign w_wdClear = (r_state != S_FIRE);

  cycle_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_cycleWatchdog (
    .clk_in  (clk_in),
    .reset   (reset),
    .start   (w_wdStart),
    .clear   (w_wdClear),
    .expired (w_timeout)
  );

  // timeout_err is sticky until the next accepted header. An acknowledge
  // arriving on the expiry cycle wins, so no error is raised then.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_timeoutErr <= 1'b0;
    end else if (r_state == S_IDLE && wr) begin
      r_timeoutErr <= 1'b0;
    end else if (r_state == S_FIRE && !mc_busy && w_timeout) begin
      r_timeoutErr <= 1'b1;
    end
  end

  assign timeout_err = r_timeoutErr;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Oversize requests are checked before the zero-length
  // case; a zero-length request skips straight to raising trigger.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_INIT: begin
        if (!mc_busy) begin
          w_nextState = S_IDLE;
        end
      end
      S_IDLE: begin
        if (wr) begin
          if (w_lenTooBig) begin
            w_nextState = S_DRAIN;
          end else if (w_hdrNoPayload) begin
            w_nextState = S_FIRE;
          end else begin
            w_nextState = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_lastWord) begin
          w_nextState = S_FIRE;
        end
      end
      S_DRAIN: begin
        if (w_lastWord) begin
          w_nextState = S_IDLE;
        end
      end
      S_FIRE: begin
        if (mc_busy) begin
          w_nextState = S_RUN;
        end else if (w_timeout) begin
          w_nextState = S_IDLE;
        end
      end
      S_RUN: begin
        if (!mc_busy) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_INIT;
      end
    endcase
  end

  // Datapath and registered outputs. cmd, quad and data_send only change
  // in S_IDLE/S_LOAD, which keeps them stable from the moment trigger
  // rises until the controller has finished. trigger is raised on the
  // same edge that completes the request so it is visible one cycle after
  // the final host word.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_busy         <= 1'b1;
      r_trigger      <= 1'b0;
      r_quad         <= 1'b0;
      r_cmd          <= '0;
      r_dataSend     <= '0;
      r_readout      <= '0;
      r_readoutValid <= 1'b0;
      r_lenErr       <= 1'b0;
      r_remain       <= '0;
    end else begin
      r_readoutValid <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (!mc_busy) begin
            r_busy <= 1'b0;
          end
        end
        S_IDLE: begin
          if (wr) begin
            r_cmd    <= w_hdrCmd;
            r_quad   <= w_hdrQuad;
            r_remain <= w_hdrLen;
            r_busy   <= 1'b1;
            r_lenErr <= w_lenTooBig;
            if (!w_lenTooBig && w_hdrNoPayload) begin
              r_trigger <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (wr) begin
            r_dataSend <= {r_dataSend[DATA_W-HOST_W-1:0], wdata};
            r_remain   <= r_remain - LEN_W'(1);
            if (w_lastWord) begin
              r_trigger <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (wr) begin
            r_remain <= r_remain - LEN_W'(1);
            if (w_lastWord) begin
              r_busy <= 1'b0;
            end
          end
        end
        S_FIRE: begin
          if (mc_busy) begin
            r_trigger <= 1'b0;
          end else if (w_timeout) begin
            r_trigger <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        S_RUN: begin
          if (!mc_busy) begin
            r_readout      <= mc_readout;
            r_readoutValid <= 1'b1;
            r_busy         <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign len_err       = r_lenErr;
  assign error         = mc_error | r_lenErr | timeout_err;
  assign readout       = r_readout;
  assign readout_valid = r_readoutValid;
  assign trigger       = r_trigger;
  assign quad          = r_quad;
  assign cmd           = r_cmd;
  assign data_send     = r_dataSend;

endmodule
